// File: rtl/instr_decode_queue.sv
// instr_decode_queue: DEPTH-entry fetch queue whose head entry is decoded
// combinationally into RV32 fields, immediate and an illegal-opcode flag.
module instr_decode_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [9:0]  in_pc,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  out_pc,
  output logic [6:0]  out_opcode,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [31:0] out_imm,
  output logic        out_illegal
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW + 1)'(DEPTH);
  logic [31:0]   r_instr [DEPTH];
  logic [9:0]    r_pc [DEPTH];
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [AW:0]   r_count;
  logic          w_push, w_pop, w_legal;
  logic [31:0]   w_instr, w_imm;
  assign in_ready  = r_count < L_FULL;
  assign out_valid = r_count != '0;
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;
  // pointers are AW bits wide, so DEPTH being a power of two gives the wrap for free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push != w_pop) r_count <= w_push ? r_count + 1'b1 : r_count - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wr_ptr] <= in_instr;
      r_pc[r_wr_ptr]    <= in_pc;
    end
  end
  assign w_instr = r_instr[r_rd_ptr];
  // an unknown opcode matches no item and lands in default, flagging it illegal
  always_comb begin
    w_legal = 1'b0;
    w_imm   = '0;
    case (w_instr[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: begin
        w_legal = 1'b1;
        w_imm   = {{20{w_instr[31]}}, w_instr[31:20]};
      end
      7'h23: begin
        w_legal = 1'b1;
        w_imm   = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
      end
      7'h63: begin
        w_legal = 1'b1;
        w_imm   = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
      end
      7'h37, 7'h17: begin
        w_legal = 1'b1;
        w_imm   = {w_instr[31:12], 12'h000};
      end
      7'h6F: begin
        w_legal = 1'b1;
        w_imm   = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
      end
      7'h33: w_legal = 1'b1;
      default: ;
    endcase
  end
  assign out_pc      = out_valid ? r_pc[r_rd_ptr] : '0;
  assign out_opcode  = out_valid ? w_instr[6:0] : '0;
  assign out_rd      = out_valid ? w_instr[11:7] : '0;
  assign out_funct3  = out_valid ? w_instr[14:12] : '0;
  assign out_rs1     = out_valid ? w_instr[19:15] : '0;
  assign out_rs2     = out_valid ? w_instr[24:20] : '0;
  assign out_funct7  = out_valid ? w_instr[31:25] : '0;
  assign out_imm     = out_valid ? w_imm : '0;
  assign out_illegal = out_valid && !w_legal;
endmodule

// File: tb/tb_instr_decode_queue.sv
// tb_instr_decode_queue: table vectors, corner-case sequences and random
// traffic checked against a queue-based reference model.
module tb_instr_decode_queue;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [9:0]  in_pc = '0;
  logic        in_ready, out_valid, out_illegal;
  logic [9:0]  out_pc;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic [31:0] out_imm;
  instr_decode_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
    .in_pc(in_pc), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_illegal(out_illegal)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] instr;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } vec_t;
  typedef struct { logic [31:0] instr; logic [9:0] pc; } ent_t;
  ent_t q[$];
  vec_t vecs[10];
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  function automatic vec_t ref_dec(input logic [31:0] x);
    vec_t e;
    int v;
    logic [6:0] op;
    op = x[6:0];
    e.instr = x; e.op = op; e.rd = x[11:7]; e.f3 = x[14:12];
    e.rs1 = x[19:15]; e.rs2 = x[24:20]; e.f7 = x[31:25];
    e.ill = !(op inside {7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73});
    e.imm = '0;
    if (op inside {7'h03, 7'h13, 7'h67, 7'h73}) begin
      v = int'(x[31:20]);
      if (v >= 2048) v -= 4096;
      e.imm = 32'(v);
    end else if (op == 7'h23) begin
      v = int'(x[31:25]) * 32 + int'(x[11:7]);
      if (v >= 2048) v -= 4096;
      e.imm = 32'(v);
    end else if (op == 7'h63) begin
      v = int'(x[31]) * 4096 + int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2;
      if (v >= 4096) v -= 8192;
      e.imm = 32'(v);
    end else if (op inside {7'h37, 7'h17}) begin
      e.imm = x & 32'hFFFFF000;
    end else if (op == 7'h6F) begin
      v = int'(x[31]) * 1048576 + int'(x[19:12]) * 4096 + int'(x[20]) * 2048 + int'(x[30:21]) * 2;
      if (v >= 1048576) v -= 2097152;
      e.imm = 32'(v);
    end
    return e;
  endfunction
  task automatic chk_fields(input string tag, input vec_t e, input logic [9:0] pc);
    chk({tag, "/pc"}, 32'(out_pc), 32'(pc));
    chk({tag, "/opcode"}, 32'(out_opcode), 32'(e.op));
    chk({tag, "/rd"}, 32'(out_rd), 32'(e.rd));
    chk({tag, "/rs1"}, 32'(out_rs1), 32'(e.rs1));
    chk({tag, "/rs2"}, 32'(out_rs2), 32'(e.rs2));
    chk({tag, "/funct3"}, 32'(out_funct3), 32'(e.f3));
    chk({tag, "/funct7"}, 32'(out_funct7), 32'(e.f7));
    chk({tag, "/imm"}, out_imm, e.imm);
    chk({tag, "/illegal"}, 32'(out_illegal), 32'(e.ill));
  endtask
  task automatic check_model(input string tag);
    vec_t e;
    chk({tag, "/in_ready"}, 32'(in_ready), 32'(q.size() < 4));
    chk({tag, "/out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk_fields(tag, ref_dec(q[0].instr), q[0].pc);
    else begin
      e = '{default: '0};
      chk_fields(tag, e, 10'd0);
    end
  endtask
  task automatic tick();
    bit push, pop;
    push = in_valid && q.size() < 4 && !flush;
    pop = q.size() != 0 && out_ready && !flush;
    @(posedge clk);
    if (!rst_n || flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{in_instr, in_pc});
    end
    #1;
  endtask
  task automatic push_one(input logic [31:0] ins, input logic [9:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    tick();
    in_valid = 1'b0;
  endtask
  function automatic logic [31:0] rand_instr();
    logic [6:0] ops[10] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    logic [31:0] t;
    t = $urandom();
    if ($urandom_range(0, 9) != 0) t[6:0] = ops[$urandom_range(0, 9)];
    return t;
  endfunction
  initial begin
    vecs[0] = '{32'h00500093, 7'h13, 5'd1,  5'd0,  5'd5,  3'd0, 7'h00, 32'h00000005, 1'b0};
    vecs[1] = '{32'hFFF00113, 7'h13, 5'd2,  5'd0,  5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 1'b0};
    vecs[2] = '{32'h123452B7, 7'h37, 5'd5,  5'd8,  5'd3,  3'd5, 7'h09, 32'h12345000, 1'b0};
    vecs[3] = '{32'h00000000, 7'h00, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, 1'b1};
    vecs[4] = '{32'hFE112E23, 7'h23, 5'd28, 5'd2,  5'd1,  3'd2, 7'h7F, 32'hFFFFFFFC, 1'b0};
    vecs[5] = '{32'hFE208CE3, 7'h63, 5'd25, 5'd1,  5'd2,  3'd0, 7'h7F, 32'hFFFFFFF8, 1'b0};
    vecs[6] = '{32'h001000EF, 7'h6F, 5'd1,  5'd0,  5'd1,  3'd0, 7'h00, 32'h00000800, 1'b0};
    vecs[7] = '{32'h002081B3, 7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 32'h00000000, 1'b0};
    vecs[8] = '{32'hFFFFF297, 7'h17, 5'd5,  5'd31, 5'd31, 3'd7, 7'h7F, 32'hFFFFF000, 1'b0};
    vecs[9] = '{32'h0000007F, 7'h7F, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, 1'b1};
    #12;
    check_model("reset");
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      check_model("vec_pre");
      push_one(vecs[i].instr, 10'(i * 4));
      chk_fields($sformatf("vec%0d", i), vecs[i], 10'(i * 4));
      check_model("vec_model");
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    for (int k = 0; k < 4; k++) push_one(32'h00000013, 10'(k * 4));
    chk("full/in_ready", 32'(in_ready), 32'd0);
    push_one(32'h00100093, 10'd16);
    check_model("full_5th");
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("full/order", 32'(out_pc), 32'(k * 4));
      tick();
    end
    out_ready = 1'b0;
    chk("full/drained", 32'(out_valid), 32'd0);
    push_one(32'h00000013, 10'd100);
    push_one(32'h00000013, 10'd104);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_pc = 10'(108 + 4 * k); in_instr = rand_instr();
      chk("simul/pc", 32'(out_pc), 32'(100 + 4 * k));
      tick();
      check_model("simul");
    end
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("simul/tail", 32'(out_pc), 32'(140 + 4 * k));
      tick();
    end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) push_one(rand_instr(), 10'(200 + 4 * k));
    in_valid = 1'b1; in_pc = 10'd212; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush/out_valid", 32'(out_valid), 32'd0);
    chk("flush/in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("flush/not_enq", 32'(out_valid), 32'd0);
    push_one(rand_instr(), 10'd300);
    push_one(rand_instr(), 10'd304);
    in_valid = 1'b1; in_pc = 10'd308;
    #3;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("rst/out_valid", 32'(out_valid), 32'd0);
    chk("rst/in_ready", 32'(in_ready), 32'd1);
    chk("rst/out_pc", 32'(out_pc), 32'd0);
    tick();
    check_model("rst_held");
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    check_model("rst_after");
    for (int c = 0; c < 600; c++) begin
      in_valid = $urandom_range(0, 99) < 60;
      out_ready = $urandom_range(0, 99) < 50;
      flush = $urandom_range(0, 99) < 3;
      in_instr = rand_instr();
      in_pc = 10'($urandom());
      tick();
      check_model("rand");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
